// File: rtl/axi_lite_master_bridge.sv
// Word-addressed request/response streams to an AXI4-Lite master port; independent read and write engines.
// Optional error-response counter (err_cnt) is built when AXI_LITE_MASTER_ERR_EN is defined.
module axi_lite_master_bridge #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ar,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [DATA_W-1:0] r,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ADDR_W+1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W+1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
`ifdef AXI_LITE_MASTER_ERR_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R, RD_OUT} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_B, WR_OUT} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic              ar_ready_next, arvalid_next, rready_next, r_valid_next;
  logic              w_ready_next, awvalid_next, wvalid_next, bready_next, b_valid_next;
  logic [ADDR_W+1:0] araddr_next, awaddr_next;
  logic [DATA_W-1:0] r_next, wdata_next;
  logic              ar_hs, w_hs, r_beat, b_beat, aw_left, w_left;

  assign m_axi_wstrb = 4'b1111;

  assign ar_hs   = ar_valid & ar_ready;
  assign w_hs    = w_valid & w_ready;
  assign r_beat  = m_axi_rvalid & m_axi_rready;
  assign b_beat  = m_axi_bvalid & m_axi_bready;
  assign aw_left = m_axi_awvalid & ~m_axi_awready;
  assign w_left  = m_axi_wvalid & ~m_axi_wready;

  // Every handshake output is registered from the next state, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= RD_IDLE;
      wr_state      <= WR_IDLE;
      ar_ready      <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      r_valid       <= 1'b0;
      w_ready       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      b_valid       <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      r             <= '0;
    end else begin
      rd_state      <= rd_next;
      wr_state      <= wr_next;
      ar_ready      <= ar_ready_next;
      m_axi_arvalid <= arvalid_next;
      m_axi_rready  <= rready_next;
      r_valid       <= r_valid_next;
      w_ready       <= w_ready_next;
      m_axi_awvalid <= awvalid_next;
      m_axi_wvalid  <= wvalid_next;
      m_axi_bready  <= bready_next;
      b_valid       <= b_valid_next;
      m_axi_araddr  <= araddr_next;
      m_axi_awaddr  <= awaddr_next;
      m_axi_wdata   <= wdata_next;
      r             <= r_next;
    end
  end

  always_comb begin
    rd_next     = rd_state;
    araddr_next = m_axi_araddr;
    r_next      = r;
    case (rd_state)
      RD_IDLE: if (ar_hs) begin
        rd_next     = RD_AR;
        araddr_next = {ar, 2'b00};
      end
      RD_AR:   if (m_axi_arvalid && m_axi_arready) rd_next = RD_R;
      RD_R:    if (r_beat) begin
        rd_next = RD_OUT;
        r_next  = m_axi_rdata;
      end
      RD_OUT:  if (r_valid && r_ready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
    ar_ready_next = (rd_next == RD_IDLE);
    arvalid_next  = (rd_next == RD_AR);
    rready_next   = (rd_next == RD_R);
    r_valid_next  = (rd_next == RD_OUT);
  end

  // AW and W retire independently; the request phase ends once neither channel still has a beat pending.
  always_comb begin
    wr_next     = wr_state;
    awaddr_next = m_axi_awaddr;
    wdata_next  = m_axi_wdata;
    case (wr_state)
      WR_IDLE: if (w_hs) begin
        wr_next     = WR_REQ;
        awaddr_next = {wa, 2'b00};
        wdata_next  = wd;
      end
      WR_REQ:  if (!aw_left && !w_left) wr_next = WR_B;
      WR_B:    if (b_beat) wr_next = WR_OUT;
      WR_OUT:  if (b_valid && b_ready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
    w_ready_next = (wr_next == WR_IDLE);
    awvalid_next = (wr_next == WR_REQ) && ((wr_state == WR_IDLE) || aw_left);
    wvalid_next  = (wr_next == WR_REQ) && ((wr_state == WR_IDLE) || w_left);
    bready_next  = (wr_next == WR_B);
    b_valid_next = (wr_next == WR_OUT);
  end

`ifdef AXI_LITE_MASTER_ERR_EN
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [7:0] err_cnt_next;

  // Error R and B beats landing on the same edge both count; the sum saturates at 255.
  always_comb begin
    err_inc      = {1'b0, (r_beat && (m_axi_rresp != 2'b00))} +
                   {1'b0, (b_beat && (m_axi_bresp != 2'b00))};
    err_sum      = {1'b0, err_cnt} + {7'd0, err_inc};
    err_cnt_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt <= 8'd0;
    else     err_cnt <= err_cnt_next;
  end
`else
  logic resp_unused;
  assign resp_unused = ^{m_axi_rresp, m_axi_bresp};
`endif

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge; the bench plays the AXI-Lite slave by hand.
// Error-counter checks are compiled in when AXI_LITE_MASTER_ERR_EN is defined.
module tb_axi_lite_master_bridge;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk, rst;
  logic [ADDR_W-1:0] ar, wa;
  logic              ar_valid, ar_ready, w_valid, w_ready;
  logic [DATA_W-1:0] wd, r;
  logic              r_valid, r_ready, b_valid, b_ready;
  logic [ADDR_W+1:0] m_axi_awaddr, m_axi_araddr;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]        m_axi_wstrb;
  logic [1:0]        m_axi_bresp, m_axi_rresp;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;
`ifdef AXI_LITE_MASTER_ERR_EN
  logic [7:0]        err_cnt;
`endif

  int checks = 0;
  int passes = 0;

  axi_lite_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ar(ar), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .wa(wa), .wd(wd), .w_valid(w_valid), .w_ready(w_ready),
    .r(r), .r_valid(r_valid), .r_ready(r_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
`ifdef AXI_LITE_MASTER_ERR_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  task automatic slave_idle();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
  endtask

  task automatic applyStimulus(input logic do_rst);
    ar = '0; ar_valid = 0; wa = '0; wd = '0; w_valid = 0; r_ready = 0; b_ready = 0;
    slave_idle();
    rst = do_rst;
  endtask

  task automatic wait_ar_ready();
    int n = 0;
    while (!ar_ready && n < 10) begin step(); n++; end
    checkOutput("ar_ready_wait", ar_ready, 1);
  endtask

  task automatic wait_w_ready();
    int n = 0;
    while (!w_ready && n < 10) begin step(); n++; end
    checkOutput("w_ready_wait", w_ready, 1);
  endtask

  // Zero-wait slave read; the handshake edge counts as the first of the latency edges.
  task automatic read_txn(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int lat;
    logic [ADDR_W+1:0] exp_addr;
    exp_addr = {addr, 2'b00};
    m_axi_arready = 1; m_axi_rvalid = 1; m_axi_rdata = data; m_axi_rresp = resp;
    wait_ar_ready();
    ar = addr; ar_valid = 1;
    step();
    ar_valid = 0;
    checkOutput("rd_araddr", m_axi_araddr, exp_addr);
    checkOutput("rd_arvalid", m_axi_arvalid, 1);
    lat = 1;
    while (!r_valid && lat < 20) begin step(); lat++; end
    checkOutput("rd_latency", lat, 3);
    checkOutput("rd_data", r, data);
    r_ready = 1;
    step();
    r_ready = 0;
    slave_idle();
  endtask

  task automatic write_txn(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int n;
    logic [ADDR_W+1:0] exp_addr;
    exp_addr = {addr, 2'b00};
    m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 1; m_axi_bresp = resp;
    wait_w_ready();
    wa = addr; wd = data; w_valid = 1;
    step();
    w_valid = 0;
    checkOutput("wr_awaddr", m_axi_awaddr, exp_addr);
    checkOutput("wr_wdata", m_axi_wdata, data);
    n = 0;
    while (!b_valid && n < 20) begin step(); n++; end
    checkOutput("wr_b_valid", b_valid, 1);
    b_ready = 1;
    step();
    b_ready = 0;
    slave_idle();
  endtask

  // Read and write launched on the same edge against a zero-wait slave.
  task automatic both_txn(input logic [ADDR_W-1:0] raddr, input logic [31:0] rdata, input logic [1:0] rresp,
                          input logic [ADDR_W-1:0] waddr, input logic [31:0] wdata, input logic [1:0] bresp);
    int n;
    m_axi_arready = 1; m_axi_rvalid = 1; m_axi_rdata = rdata; m_axi_rresp = rresp;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 1; m_axi_bresp = bresp;
    wait_ar_ready();
    wait_w_ready();
    ar = raddr; ar_valid = 1; wa = waddr; wd = wdata; w_valid = 1;
    step();
    ar_valid = 0; w_valid = 0;
    n = 0;
    while (!r_valid && !b_valid && n < 20) begin step(); n++; end
    checkOutput("both_r_valid", r_valid, 1);
    checkOutput("both_b_valid", b_valid, 1);
    checkOutput("both_r_data", r, rdata);
    checkOutput("both_awaddr", m_axi_awaddr, {waddr, 2'b00});
    checkOutput("both_wdata", m_axi_wdata, wdata);
    r_ready = 1; b_ready = 1;
    step();
    r_ready = 0; b_ready = 0;
    slave_idle();
  endtask

  initial begin
    int pulses;
    int n;
    logic [31:0] held;

    // Reset state
    applyStimulus(1'b1);
    step();
    step();
    checkOutput("rst_handshakes",
                {ar_ready, w_ready, r_valid, b_valid, m_axi_awvalid, m_axi_wvalid,
                 m_axi_bready, m_axi_arvalid, m_axi_rready}, 9'd0);
    checkOutput("rst_addrs", {m_axi_araddr, m_axi_awaddr}, 22'd0);
    checkOutput("rst_data", {r, m_axi_wdata}, 64'd0);
    checkOutput("wstrb", m_axi_wstrb, 4'hF);
    rst = 0;
    step();

    // Test 1: zero-wait read
    read_txn(9'h005, 32'hDEADBEEF, 2'b00);
    checkOutput("t1_araddr", m_axi_araddr, 11'h014);
    checkOutput("t1_r", r, 32'hDEADBEEF);

    // Test 2: awready three cycles ahead of wready
    wait_w_ready();
    wa = 9'h1FF; wd = 32'h12345678; w_valid = 1; m_axi_awready = 1;
    step();
    w_valid = 0;
    checkOutput("t2_awaddr", m_axi_awaddr, 11'h7FC);
    checkOutput("t2_wdata", m_axi_wdata, 32'h12345678);
    checkOutput("t2_valids_c1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    step();
    m_axi_awready = 0;
    checkOutput("t2_valids_c2", {m_axi_awvalid, m_axi_wvalid}, 2'b01);
    step();
    checkOutput("t2_valids_c3", {m_axi_awvalid, m_axi_wvalid}, 2'b01);
    step();
    m_axi_wready = 1;
    checkOutput("t2_valids_c4", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
    step();
    m_axi_wready = 0;
    checkOutput("t2_valids_c5", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, b_valid}, 4'b0010);
    m_axi_bvalid = 1; b_ready = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      m_axi_bvalid = 0;
      if (b_valid) pulses++;
    end
    b_ready = 0;
    checkOutput("t2_b_pulses", pulses, 1);
    checkOutput("t2_w_ready_back", w_ready, 1);

    // Test 3: r_ready held low for 10 cycles in the output state
    m_axi_arready = 1; m_axi_rvalid = 1; m_axi_rdata = 32'hA5A50F0F;
    wait_ar_ready();
    ar = 9'h00A; ar_valid = 1;
    step();
    ar = 9'h0FF;
    n = 0;
    while (!r_valid && n < 20) begin step(); n++; end
    checkOutput("t3_r_valid", r_valid, 1);
    held = r;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("t3_stall", {r_valid, ar_ready, m_axi_arvalid}, 3'b100);
      checkOutput("t3_r_stable", r, held);
    end
    checkOutput("t3_r_value", held, 32'hA5A50F0F);
    ar_valid = 0; r_ready = 1;
    step();
    r_ready = 0;
    slave_idle();
    checkOutput("t3_released", {r_valid, ar_ready, m_axi_arvalid}, 3'b010);

    // Test 4: simultaneous read and write
    both_txn(9'h033, 32'hCAFEF00D, 2'b00, 9'h044, 32'h0BADC0DE, 2'b00);

    // Test 5: reset while read waits in RD_R and write waits in WR_REQ
    m_axi_arready = 1;
    wait_ar_ready();
    wait_w_ready();
    ar = 9'h011; ar_valid = 1; wa = 9'h022; wd = 32'h55AA55AA; w_valid = 1;
    step();
    ar_valid = 0; w_valid = 0;
    step();
    checkOutput("t5_pre", {m_axi_rready, m_axi_awvalid, m_axi_wvalid}, 3'b111);
    rst = 1;
    step();
    checkOutput("t5_rst_handshakes",
                {ar_ready, w_ready, r_valid, b_valid, m_axi_awvalid, m_axi_wvalid,
                 m_axi_bready, m_axi_arvalid, m_axi_rready}, 9'd0);
    rst = 0;
    slave_idle();
    step();
    checkOutput("t5_idle_again", {ar_ready, w_ready}, 2'b11);
    read_txn(9'h0F0, 32'h600DF00D, 2'b00);
    write_txn(9'h0F1, 32'h13579BDF, 2'b00);

`ifdef AXI_LITE_MASTER_ERR_EN
    // Test 6: error response counting and saturation
    checkOutput("t6_err_start", err_cnt, 8'd0);
    for (int i = 0; i < 3; i++) read_txn(9'(i + 1), 32'h0000E000 + 32'(i), 2'b10);
    checkOutput("t6_err_3", err_cnt, 8'd3);
    write_txn(9'h100, 32'hFFFF0000, 2'b11);
    checkOutput("t6_err_4", err_cnt, 8'd4);
    both_txn(9'h050, 32'h01234567, 2'b01, 9'h051, 32'h89ABCDEF, 2'b10);
    checkOutput("t6_err_6", err_cnt, 8'd6);
    for (int i = 0; i < 294; i++) read_txn(9'(i), 32'(i), 2'b10);
    checkOutput("t6_err_sat", err_cnt, 8'd255);
    rst = 1;
    step();
    rst = 0;
    checkOutput("t6_err_cleared", err_cnt, 8'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
